mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 100 ++++++++++
 tb/tb_mem_access_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with a 256-byte little-endian data memory behind an IDLE/ACCESS/RESP FSM.
// Optional MEM_MISALIGN_TRAP_EN flags misaligned accesses as errors instead of performing them bytewise.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [63:0] addr_in,
  input  logic [63:0] write_data_in,
  input  logic        memread_in,
  input  logic        memwrite_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic        memtoreg_in,
  input  logic        regwrite_in,
  output logic        stall_out,
  output logic        valid_out,
  output logic [63:0] read_data_out,
  output logic [63:0] result_alu_out,
  output logic [4:0]  rd_out,
  output logic        memtoreg_out,
  output logic        regwrite_out,
  output logic        err_out
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [63:0] addr_q, wdata_q;
  logic rd_q, wr_q, mtr_q, rw_q;
  logic [2:0] f3_q;
  logic [4:0] rdn_q;
  logic [255:0][7:0] mem;
  logic [3:0] nbytes;
  logic illegal, err_c;
  logic [63:0] raw, ld_c;
  always_comb begin
    nbytes = 4'd1 << f3_q[1:0];
    illegal = (rd_q == wr_q) || (rd_q ? f3_q == 3'b111 : f3_q[2]);
`ifdef MEM_MISALIGN_TRAP_EN
    err_c = illegal || ((addr_q[2:0] & 3'(nbytes - 4'd1)) != 3'd0);
`else
    err_c = illegal;
`endif
    raw = '0;
    // byte lanes wrap modulo 256 through the 8-bit index addition
    for (int i = 0; i < 8; i++)
      if (4'(i) < nbytes) raw[8*i +: 8] = mem[addr_q[7:0] + 8'(i)];
    ld_c = (err_c || !rd_q) ? '0 :
           f3_q[2]          ? raw :
           f3_q[1:0] == 2'd0 ? {{56{raw[7]}}, raw[7:0]} :
           f3_q[1:0] == 2'd1 ? {{48{raw[15]}}, raw[15:0]} :
           f3_q[1:0] == 2'd2 ? {{32{raw[31]}}, raw[31:0]} : raw;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      mtr_q <= 1'b0;
      rw_q <= 1'b0;
      f3_q <= '0;
      rdn_q <= '0;
      read_data_out <= '0;
      err_out <= 1'b0;
    end else if (state == IDLE && valid_in) begin
      state <= (memread_in || memwrite_in) ? ACCESS : RESP;
      addr_q <= addr_in;
      wdata_q <= write_data_in;
      rd_q <= memread_in;
      wr_q <= memwrite_in;
      mtr_q <= memtoreg_in;
      rw_q <= regwrite_in;
      f3_q <= funct3_in;
      rdn_q <= rd_in;
      read_data_out <= '0;
      err_out <= 1'b0;
    end else if (state == ACCESS) begin
      state <= RESP;
      read_data_out <= ld_c;
      err_out <= err_c;
    end else if (state == RESP) begin
      state <= IDLE;
      read_data_out <= '0;
      err_out <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mem <= '0;
    else if (state == ACCESS && wr_q && !err_c)
      for (int i = 0; i < 8; i++)
        if (4'(i) < nbytes) mem[addr_q[7:0] + 8'(i)] <= wdata_q[8*i +: 8];
  end
  assign stall_out = state != IDLE;
  assign valid_out = state == RESP;
  assign result_alu_out = addr_q;
  assign rd_out = rdn_q;
  assign memtoreg_out = mtr_q;
  assign regwrite_out = rw_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage; honours MEM_MISALIGN_TRAP_EN like the DUT.
module tb_mem_access_stage;
  logic clk = 1'b0, reset = 1'b0, valid_in = 1'b0;
  logic [63:0] addr_in = '0, write_data_in = '0;
  logic memread_in = 1'b0, memwrite_in = 1'b0, memtoreg_in = 1'b0, regwrite_in = 1'b0;
  logic [2:0] funct3_in = '0;
  logic [4:0] rd_in = '0;
  logic stall_out, valid_out, memtoreg_out, regwrite_out, err_out;
  logic [63:0] read_data_out, result_alu_out;
  logic [4:0] rd_out;
  int errors = 0, checks = 0;
  typedef struct {
    logic [63:0] rdata, alu;
    logic [4:0] rd;
    logic mtr, rw, err;
    int lat;
  } exp_t;
  exp_t sb[$];
  logic [7:0] m [256];
  logic [63:0] got;
  mem_access_stage dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .addr_in(addr_in),
    .write_data_in(write_data_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .funct3_in(funct3_in), .rd_in(rd_in), .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
    .stall_out(stall_out), .valid_out(valid_out), .read_data_out(read_data_out),
    .result_alu_out(result_alu_out), .rd_out(rd_out), .memtoreg_out(memtoreg_out),
    .regwrite_out(regwrite_out), .err_out(err_out)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 64'(valid_out), 0);
    check({tag, "_stall"}, 64'(stall_out), 0);
    check({tag, "_rdata"}, read_data_out, 0);
    check({tag, "_alu"}, result_alu_out, 0);
    check({tag, "_side"}, 64'({rd_out, memtoreg_out, regwrite_out, err_out}), 0);
  endtask
  // one request; while stalled, a bogus store to 0x21 is offered and must be ignored
  task automatic req(input string tag, input logic r, input logic w, input logic [2:0] f3,
                     input logic [63:0] a, input logic [63:0] wd, input logic [4:0] rdn,
                     input logic mtr, input logic rw, output logic [63:0] rdata);
    exp_t e;
    int n, lat;
    logic bad;
    logic [63:0] v;
    logic [7:0] idx;
    n = 1 << f3[1:0];
    bad = (r && w) || (r && f3 == 3'b111) || (w && f3[2]);
`ifdef MEM_MISALIGN_TRAP_EN
    if ((r || w) && (int'(a[2:0]) % n) != 0) bad = 1'b1;
`endif
    e.err = (r || w) && bad;
    v = '0;
    if (r && !e.err) begin
      for (int i = 0; i < n; i++) begin
        idx = a[7:0] + 8'(i);
        v[8*i +: 8] = m[idx];
      end
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    end
    if (w && !e.err)
      for (int i = 0; i < n; i++) begin
        idx = a[7:0] + 8'(i);
        m[idx] = wd[8*i +: 8];
      end
    e.rdata = v; e.alu = a; e.rd = rdn; e.mtr = mtr; e.rw = rw;
    e.lat = (r || w) ? 2 : 1;
    sb.push_back(e);
    valid_in = 1'b1; memread_in = r; memwrite_in = w; funct3_in = f3; addr_in = a;
    write_data_in = wd; rd_in = rdn; memtoreg_in = mtr; regwrite_in = rw;
    @(posedge clk); #1;
    memread_in = 1'b0; memwrite_in = 1'b1; funct3_in = 3'b000; addr_in = 64'h21; write_data_in = 64'h5A;
    check({tag, "_stall"}, 64'(stall_out), 1);
    lat = 1;
    while (!valid_out && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    valid_in = 1'b0; memwrite_in = 1'b0;
    e = sb.pop_front();
    check({tag, "_valid"}, 64'(valid_out), 1);
    check({tag, "_lat"}, 64'(lat), 64'(e.lat));
    check({tag, "_rdata"}, read_data_out, e.rdata);
    check({tag, "_err"}, 64'(err_out), 64'(e.err));
    check({tag, "_alu"}, result_alu_out, e.alu);
    check({tag, "_side"}, 64'({rd_out, memtoreg_out, regwrite_out}), 64'({e.rd, e.mtr, e.rw}));
    rdata = read_data_out;
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'({valid_out, stall_out}), 0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    #2;
    check_idle_outputs("rst0");
    #10 reset = 1'b1;
    req("sd10", 0, 1, 3'b011, 64'h10, 64'h1122334455667788, 5'd1, 0, 0, got);
    req("ld10", 1, 0, 3'b011, 64'h10, 0, 5'd2, 1, 1, got);
    check("ld10_val", got, 64'h1122334455667788);
    req("sd20", 0, 1, 3'b011, 64'h20, 64'h0706050403020100, 5'd3, 0, 0, got);
    req("sb21", 0, 1, 3'b000, 64'h21, 64'hFFFF_FF80, 5'd3, 0, 0, got);
    req("lb21", 1, 0, 3'b000, 64'h21, 0, 5'd4, 1, 1, got);
    check("lb21_val", got, 64'hFFFFFFFFFFFFFF80);
    req("lbu21", 1, 0, 3'b100, 64'h21, 0, 5'd5, 1, 1, got);
    check("lbu21_val", got, 64'h80);
    req("ld20", 1, 0, 3'b011, 64'h20, 0, 5'd6, 1, 1, got);
    check("ld20_val", got, 64'h0706050403028000);
    req("alu", 0, 0, 3'b000, 64'hABC, 64'h1234, 5'd7, 0, 1, got);
    check("alu_val", got, 0);
    req("sd00", 0, 1, 3'b011, 64'h0, 64'h8877665544332211, 5'd8, 0, 0, got);
    req("lw102", 1, 0, 3'b010, 64'h102, 0, 5'd9, 1, 1, got);
`ifdef MEM_MISALIGN_TRAP_EN
    check("lw102_val", got, 0);
`else
    check("lw102_val", got, 64'h66554433);
`endif
    req("sd30", 0, 1, 3'b011, 64'h30, 64'hF0E0D0C0B0A09080, 5'd10, 0, 0, got);
    req("lh30", 1, 0, 3'b001, 64'h30, 0, 5'd11, 1, 1, got);
    check("lh30_val", got, 64'hFFFFFFFFFFFF9080);
    req("lhu30", 1, 0, 3'b101, 64'h30, 0, 5'd12, 1, 1, got);
    req("lw34", 1, 0, 3'b010, 64'h34, 0, 5'd13, 1, 1, got);
    check("lw34_val", got, 64'hFFFFFFFFF0E0D0C0);
    req("lwu34", 1, 0, 3'b110, 64'h34, 0, 5'd14, 1, 1, got);
    req("sh38", 0, 1, 3'b001, 64'h38, 64'hAAAA_BEEF, 5'd15, 0, 0, got);
    req("sw3c", 0, 1, 3'b010, 64'h13C, 64'h5555_CAFE_F00D, 5'd16, 0, 0, got);
    req("ld38", 1, 0, 3'b011, 64'h38, 0, 5'd17, 1, 1, got);
    req("sdfc", 0, 1, 3'b011, 64'hFC, 64'hDEADBEEF01234567, 5'd18, 0, 0, got);
    req("ldfc", 1, 0, 3'b011, 64'hFC, 0, 5'd19, 1, 1, got);
    req("ld00", 1, 0, 3'b011, 64'h0, 0, 5'd20, 1, 1, got);
    req("lh31", 1, 0, 3'b001, 64'h31, 0, 5'd21, 1, 1, got);
    req("ill_ld", 1, 0, 3'b111, 64'h30, 0, 5'd22, 1, 1, got);
    req("ill_rw", 1, 1, 3'b011, 64'h30, 64'h1, 5'd23, 1, 1, got);
    req("ill_st", 0, 1, 3'b100, 64'h30, 64'h0, 5'd24, 0, 0, got);
    req("ld30", 1, 0, 3'b011, 64'h30, 0, 5'd25, 1, 1, got);
    check("ld30_val", got, 64'hF0E0D0C0B0A09080);
    req("sd40", 0, 1, 3'b011, 64'h40, 64'h0123456789ABCDEF, 5'd26, 0, 0, got);
    valid_in = 1'b1; memwrite_in = 1'b1; funct3_in = 3'b011; addr_in = 64'h40;
    write_data_in = 64'hCAFEBABECAFEBABE; rd_in = 5'd27; regwrite_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; memwrite_in = 1'b0; regwrite_in = 1'b0;
    check("rst_mid_stall", 64'(stall_out), 1);
    check("rst_mid_alu", result_alu_out, 64'h40);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    #1 reset = 1'b1;
    req("ld40", 1, 0, 3'b011, 64'h40, 0, 5'd28, 1, 1, got);
    check("ld40_val", got, 0);
    req("ld10b", 1, 0, 3'b011, 64'h10, 0, 5'd29, 1, 1, got);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
